fir_acc_sink: RTL
=================

Name: fir_acc_sink

Overview:
- Output end of the systolic FIR tap chain. Accepts the final accumulator word from the last tap on each i_ce strobe.
- Discards chain warm-up outputs, then rounds and saturates each OW-bit accumulator to RW bits.
- Buffers results in a small FIFO and presents them on a valid/ready stream to the downstream consumer (bus-side reader or DMA).

Parameters:
- OW, 40, accumulator input width (signed).
- RW, 16, result width (signed).
- SHIFT, 15, LSBs dropped by rounding; must be >= 1 and < OW.
- WARMUP, 8, number of accepted accumulator words discarded after reset or flush; 0 disables warm-up.
- DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ce  in  1  chain clock enable; i_acc is sampled when high.
- i_acc  in  OW  last-tap accumulator, signed two's complement.
- i_flush  in  1  synchronous clear of pipeline, FIFO, warm-up count and sticky flags.
- o_data  out  RW  FIFO head, signed.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready.
- o_overflow  out  1  sticky; a result was dropped because the FIFO was full.
- o_filling  out  1  high while in FILL state.

Behaviour:
- Reset (async assert, sync release):
  - State = FILL, or RUN if WARMUP=0.
  - Warm-up counter, FIFO pointers, pipeline valid and o_overflow all cleared.
  - o_data = 0, o_valid = 0.
  - o_filling = 1 if WARMUP>0, otherwise 0.
- FSM:
  - FILL: each i_ce increments the counter and the word is discarded. When the count reaches WARMUP, go to RUN; the WARMUP-th word is still discarded.
  - RUN: each i_ce word enters the pipeline.
  - i_flush in any state: returns to FILL (RUN if WARMUP=0).
- Arithmetic, stage 1 (registered on the i_ce edge):
  - s = sext(i_acc, OW+1) + 2^(SHIFT-1).
  - q = s >>> SHIFT (arithmetic shift; round-half-up).
  - If q > 2^(RW-1)-1, result = 0x7FFF (RW=16). If q < -2^(RW-1), result = 0x8000. Otherwise result = q[RW-1:0].
- Stage 2: the pipeline word is written to the FIFO on the next edge.
- Latency: i_ce high in cycle n (RUN) -> o_valid high in cycle n+2 if the FIFO was empty.
- FIFO:
  - o_data shows the head entry.
  - o_data and o_valid hold stable while o_valid & !i_ready.
  - Pop on o_valid & i_ready.
- Full:
  - A write when full with no pop in the same cycle drops the new word and sets o_overflow.
  - Write and pop in the same cycle when full: both succeed and the count is unchanged.
- Empty: o_data holds the last popped value (0 after reset/flush). Write and pop on an empty FIFO cannot coincide; o_valid is low.
- i_flush and i_ce in the same cycle: flush wins. The word is discarded and the counter is not incremented.
- i_flush clears o_overflow, the FIFO and the pipeline on the next edge. o_valid = 0 from the next cycle.
- Reset mid-burst: all state is lost immediately; no partial outputs.

Optional Feature:
- Macro: FIR_SINK_SAT_CNT_EN.
- Defined: adds output port o_sat_cnt (16 bits). It increments on each RUN-state result clipped by saturation, whether or not the word is later dropped. It saturates at 0xFFFF and is cleared by reset and i_flush.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
All scenarios use OW=40, RW=16, SHIFT=15, DEPTH=4. Scenarios 2-6 use WARMUP=0 unless stated.
- Warm-up (WARMUP=2): i_acc 0x10000, 0x20000, 0x18000 on three i_ce -> first two discarded, o_filling falls after the 2nd; o_data=0x0003 with o_valid two cycles after the 3rd.
- Rounding: i_acc 16384 -> 0x0001; -16384 -> 0x0000; -16385 -> 0xFFFF; 49151 -> 0x0001.
- Saturation: i_acc 2^31 -> 0x7FFF; -2^31 -> 0x8000; with the macro defined, o_sat_cnt = 2.
- Backpressure: i_ready=0, six i_ce words 1..6 (i_acc = k*32768) -> 4 stored, o_overflow=1. Then i_ready=1 -> pops 1, 2, 3, 4 in order, then o_valid=0.
- Flush collision: FIFO holds 2 words, i_flush and i_ce both high in one cycle -> next cycle o_valid=0, o_overflow=0, state FILL (WARMUP=2), that i_ce word never appears.
- Async reset mid-burst: assert i_rst_n=0 between clock edges with 3 words queued -> o_valid=0 and o_data=0 immediately. After release, the first 2 words are discarded (WARMUP=2).

Source files
------------

// File: rtl/fir_acc_sink_if.sv
// Result stream between fir_acc_sink and its downstream consumer.
//   data  : signed result word at the FIFO head
//   valid : data holds an unread result
//   ready : consumer takes data on valid & ready
interface fir_acc_sink_if #(
    parameter int unsigned RW = 16
) ();
    logic [RW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fir_acc_sink.sv
// fir_acc_sink: output end of the systolic FIR tap chain.
// Drops the chain warm-up words, rounds and saturates each OW-bit accumulator
// to RW bits, and queues results in a small FIFO behind a valid/ready stream.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_ce        chain clock enable; i_acc sampled when high
//   i_acc       last-tap accumulator (signed, OW bits)
//   i_flush     synchronous clear of pipeline, FIFO, warm-up count, flags
//   str         result stream (master): data / valid / ready
//   o_overflow  sticky: a result was dropped because the FIFO was full
//   o_filling   high while the warm-up words are being discarded
//   o_sat_cnt   count of saturated results (only with FIR_SINK_SAT_CNT_EN)
//
// Optional feature macro: FIR_SINK_SAT_CNT_EN
module fir_acc_sink #(
    parameter int unsigned OW     = 40,
    parameter int unsigned RW     = 16,
    parameter int unsigned SHIFT  = 15,
    parameter int unsigned WARMUP = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce,
    input  logic [OW-1:0]     i_acc,
    input  logic              i_flush,
    fir_acc_sink_if.master    str,
    output logic              o_overflow,
    output logic              o_filling
`ifdef FIR_SINK_SAT_CNT_EN
    ,
    output logic [15:0]       o_sat_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    localparam logic [OW:0]   ROUND   = (OW + 1)'(1) << (SHIFT - 1);
    localparam logic [RW-1:0] SAT_MAX = {1'b0, {(RW - 1){1'b1}}};
    localparam logic [RW-1:0] SAT_MIN = {1'b1, {(RW - 1){1'b0}}};

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Without warm-up the block comes out of reset/flush already running.
    localparam state_e ST_INIT = (WARMUP > 0) ? ST_FILL : ST_RUN;

    state_e          state_q, state_d;
    logic [CW-1:0]   warm_q, warm_d, warm_inc;
    logic            filling_q;
    logic            ce_run;

    // ---------------- warm-up FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_INIT;
            warm_q    <= '0;
            filling_q <= (WARMUP != 0);
        end else begin
            state_q   <= state_d;
            warm_q    <= warm_d;
            filling_q <= (state_d == ST_FILL);
        end
    end

    // ---------------- warm-up FSM: next state ----------------
    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        ce_run   = 1'b0;
        warm_inc = warm_q + CW'(1);
        if (i_flush) begin
            // flush wins over a coincident i_ce: word dropped, count not bumped
            state_d = ST_INIT;
            warm_d  = '0;
        end else if (i_ce) begin
            case (state_q)
                ST_FILL: begin
                    warm_d = warm_inc;
                    if (warm_inc == CW'(WARMUP)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN:  ce_run = 1'b1;
                default: state_d = ST_INIT;
            endcase
        end
    end

    // ---------------- round half-up, then clip to RW bits ----------------
    logic [OW:0]        rnd_sum;
    logic signed [OW:0] q;
    logic               sat_hit;
    logic [RW-1:0]      sat_word;

    always_comb begin
        rnd_sum  = {i_acc[OW-1], i_acc} + ROUND;
        q        = $signed(rnd_sum) >>> SHIFT;
        // in range when every bit from the RW-1 sign position upward agrees
        sat_hit  = !((&q[OW:RW-1]) || (~|q[OW:RW-1]));
        sat_word = sat_hit ? (q[OW] ? SAT_MIN : SAT_MAX) : q[RW-1:0];
    end

    // ---------------- stage 1 register ----------------
    logic          s1_valid_q;
    logic [RW-1:0] s1_data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else if (i_flush) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= ce_run;
            if (ce_run) begin
                s1_data_q <= sat_word;
            end
        end
    end

    // ---------------- stage 2: result FIFO ----------------
    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [RW-1:0] data_q, data_d;
    logic          valid_q;
    logic          ovf_q;
    logic          full, pop, wr_en, drop;

    // next FIFO state; the registered head is looked ahead from the next pointers
    always_comb begin
        full     = (cnt_q == (AW + 1)'(DEPTH));
        pop      = valid_q && str.ready;
        wr_en    = s1_valid_q && (!full || pop);
        drop     = s1_valid_q && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en && !pop) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (!wr_en && pop) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end
        if (cnt_d == '0) begin
            data_d = data_q;       // empty: keep showing the last popped word
        end else if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
            data_d = s1_data_q;    // new head is the word being written now
        end else begin
            data_d = mem[rd_ptr_d];
        end
    end

    // storage array carries no reset; pointers define what is live
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= s1_data_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= (cnt_d != '0);
            ovf_q    <= ovf_q | drop;
        end
    end

`ifdef FIR_SINK_SAT_CNT_EN
    // saturation event counter, sticks at all-ones
    logic [15:0] sat_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_cnt_q <= '0;
        end else if (i_flush) begin
            sat_cnt_q <= '0;
        end else if (ce_run && sat_hit && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign o_sat_cnt = sat_cnt_q;
`endif

    assign str.data   = data_q;
    assign str.valid  = valid_q;
    assign o_overflow = ovf_q;
    assign o_filling  = filling_q;

endmodule
